mcu_int_controller: RTL and testbench

//  Prioritising interrupt controller between the eight external sources INTS0..INTS7 and the

---
 rtl/mcu_int_controller.sv | 199 +++++++++++++++++++
 tb/tb_mcu_int_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_int_controller.sv
// mcu_int_controller: prioritising interrupt controller with eight edge-triggered sources.
// The sources are split into two groups that drive INT0 and INT1. Each group has its own
// request/acknowledge/end-of-interrupt sequencer.
// Optional feature: define MCU_INTC_POLARITY_EN to add the per-source polarity register
// at offset 4. Without it, every source triggers on a rising edge.
module mcu_int_controller #(
    parameter int NUM_SRC   = 8,
    parameter int INT0_SRCS = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  INTS,
    input  logic        SEL,
    input  logic [2:0]  ADDR,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] WDATA,
    output logic [15:0] RDATA,
    input  logic        INT_ACK0,
    input  logic        INT_ACK1,
    output logic        INT0,
    output logic        INT1
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SVC} state_t;

    // Bit mask with the lowest n bits set.
    function automatic logic [7:0] low_mask(input int n);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [7:0] VALID_MASK = low_mask(NUM_SRC);
    localparam logic [7:0] GRP0_MASK  = low_mask(INT0_SRCS) & VALID_MASK;
    localparam logic [7:0] GRP1_MASK  = ~low_mask(INT0_SRCS) & VALID_MASK;

    logic [7:0]  s1_reg, s2_reg, s3_reg;
    logic [7:0]  pend_reg, pend_next;
    logic [7:0]  mask_reg;
    logic [7:0]  pol_val;
    logic [7:0]  edge_det;
    logic [15:0] rdata_reg, rd_mux;
    logic        wr_en, rd_en;
    logic [7:0]  w1c_bits;
    logic [1:0]  eoi_bits;
    logic [1:0]  int_bits, svc_bits;
    logic [2:0]  vec_bits [2];
    logic [7:0]  ack_clr  [2];
    logic        unused_wdata;

    assign wr_en        = SEL & WR;
    assign rd_en        = SEL & RD;
    assign w1c_bits     = (wr_en && ADDR == 3'd0) ? WDATA[7:0] : 8'h00;
    assign eoi_bits     = (wr_en && ADDR == 3'd3) ? WDATA[1:0] : 2'b00;
    assign unused_wdata = &{1'b0, WDATA[15:8]};

`ifdef MCU_INTC_POLARITY_EN
    logic [7:0] pol_reg;

    // Polarity register: a 1 selects falling-edge triggering for that source.
    always_ff @(posedge CLK) begin
        if (RESET)                         pol_reg <= '0;
        else if (wr_en && ADDR == 3'd4)    pol_reg <= WDATA[7:0];
    end
    assign pol_val = pol_reg;
`else
    assign pol_val = '0;
`endif

    // Two-flop synchroniser plus one history flop per source.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_reg <= '0;
            s2_reg <= '0;
            s3_reg <= '0;
        end else begin
            s1_reg <= INTS;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    // Edge detection is done under the current polarity. Changing the polarity therefore
    // re-interprets the history flop instead of faking an edge.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_edge
            assign edge_det[gi] = (s2_reg[gi] ^ pol_val[gi]) & ~(s3_reg[gi] ^ pol_val[gi]);
        end
    endgenerate

    // Pending bits: a new edge beats a W1C or an acknowledge clear in the same cycle.
    always_comb begin
        pend_next = ((pend_reg & ~w1c_bits & ~(ack_clr[0] | ack_clr[1])) | edge_det) & VALID_MASK;
    end

    // Pending and mask storage.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend_reg <= '0;
            mask_reg <= '0;
        end else begin
            pend_reg <= pend_next;
            if (wr_en && ADDR == 3'd1) mask_reg <= WDATA[7:0];
        end
    end

    // One sequencer per core interrupt input. Inside a group the lowest index wins.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grp
            localparam logic [7:0] GRP = (gi == 0) ? GRP0_MASK : GRP1_MASK;

            state_t     state_reg, state_next;
            logic [2:0] vec_reg;
            logic       int_reg;
            logic [7:0] req_vec;
            logic       req;
            logic       ack;
            logic [2:0] win_idx;
            logic [7:0] clr_mask;

            assign req_vec = pend_reg & mask_reg & GRP;
            assign req     = |req_vec;
            assign ack     = (gi == 0) ? INT_ACK0 : INT_ACK1;

            // Lowest-index pending and enabled source of this group.
            always_comb begin
                win_idx = 3'd0;
                for (int i = 7; i >= 0; i--) begin
                    if (req_vec[i]) win_idx = 3'(i);
                end
            end

            // Next state and acknowledge clear. Stray ACKs and EOIs fall through unchanged.
            always_comb begin
                state_next = state_reg;
                clr_mask   = '0;
                case (state_reg)
                    ST_IDLE: if (req) state_next = ST_REQ;
                    ST_REQ: begin
                        if (!req) begin
                            state_next = ST_IDLE;
                        end else if (ack) begin
                            state_next = ST_SVC;
                            clr_mask   = 8'b1 << win_idx;
                        end
                    end
                    ST_SVC:  if (eoi_bits[gi]) state_next = ST_IDLE;
                    default: state_next = ST_IDLE;
                endcase
            end

            // State, registered request output and latched vector.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    state_reg <= ST_IDLE;
                    int_reg   <= 1'b0;
                    vec_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    int_reg   <= (state_next == ST_REQ);
                    if (state_reg == ST_REQ && req && ack) vec_reg <= win_idx;
                end
            end

            assign ack_clr[gi]  = clr_mask;
            assign int_bits[gi] = int_reg;
            assign svc_bits[gi] = (state_reg == ST_SVC);
            assign vec_bits[gi] = vec_reg;
        end
    endgenerate

    assign INT0 = int_bits[0];
    assign INT1 = int_bits[1];

    // Read multiplexer. Offsets that are write-only or unused read as zero.
    always_comb begin
        rd_mux = '0;
        case (ADDR)
            3'd0:    rd_mux = {8'h00, pend_reg};
            3'd1:    rd_mux = {8'h00, mask_reg};
            3'd2:    rd_mux = {svc_bits[1], vec_bits[1], 4'h0, svc_bits[0], 4'h0, vec_bits[0]};
            3'd4:    rd_mux = {8'h00, pol_val};
            default: rd_mux = '0;
        endcase
    end

    // Read data is registered and held until the next read.
    always_ff @(posedge CLK) begin
        if (RESET)      rdata_reg <= '0;
        else if (rd_en) rdata_reg <= rd_mux;
    end

    assign RDATA = rdata_reg;

endmodule

// File: tb/tb_mcu_int_controller.sv
// tb_mcu_int_controller: directed scenarios followed by randomized traffic. Every cycle is
// checked against a behavioural model of the controller.
module tb_mcu_int_controller;

    logic        CLK = 1'b0;
    logic        RESET, SEL, RD, WR, INT_ACK0, INT_ACK1;
    logic [7:0]  INTS;
    logic [2:0]  ADDR;
    logic [15:0] WDATA;
    logic [15:0] RDATA;
    logic        INT0, INT1;

    always #5 CLK = ~CLK;

    mcu_int_controller #(.NUM_SRC(8), .INT0_SRCS(4)) dut (
        .CLK(CLK), .RESET(RESET), .INTS(INTS), .SEL(SEL), .ADDR(ADDR), .RD(RD), .WR(WR),
        .WDATA(WDATA), .RDATA(RDATA), .INT_ACK0(INT_ACK0), .INT_ACK1(INT_ACK1),
        .INT0(INT0), .INT1(INT1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_REQ = 1, P_SVC = 2;
    localparam logic [7:0] GRP [2] = '{8'h0F, 8'hF0};

    logic [7:0]  m_pend, m_mask, m_pol;
    logic [15:0] m_rdata;
    int          m_phase [2];
    int          m_vec   [2];
    logic [7:0]  m_samp  [$];   // m_samp[k] = INTS as sampled k+1 clocks ago

    function automatic logic [15:0] m_read(input logic [2:0] a);
        logic [15:0] v;
        v = '0;
        case (a)
            3'd0: v = {8'h00, m_pend};
            3'd1: v = {8'h00, m_mask};
            3'd2: begin
                v[15]    = (m_phase[1] == P_SVC);
                v[14:12] = 3'(m_vec[1]);
                v[7]     = (m_phase[0] == P_SVC);
                v[2:0]   = 3'(m_vec[0]);
            end
            3'd4: v = {8'h00, m_pol};
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_pol = '0; m_rdata = '0;
        m_phase[0] = P_IDLE; m_phase[1] = P_IDLE;
        m_vec[0] = 0; m_vec[1] = 0;
        m_samp = '{8'h00, 8'h00, 8'h00};
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [7:0]  now_lvl, old_lvl, new_edges, w1c, clr, cand;
        logic [15:0] rd_val;
        bit          ack, eoi;
        int          first;
        if (RESET) begin
            model_reset();
            return;
        end
        // The synchroniser delay puts the level change two samples back into the queue.
        now_lvl   = m_samp[1] ^ m_pol;
        old_lvl   = m_samp[2] ^ m_pol;
        new_edges = now_lvl & ~old_lvl;
        rd_val    = m_read(ADDR);
        w1c       = (SEL && WR && ADDR == 3'd0) ? WDATA[7:0] : 8'h00;
        clr       = '0;
        for (int g = 0; g < 2; g++) begin
            cand = m_pend & m_mask & GRP[g];
            ack  = (g == 0) ? INT_ACK0 : INT_ACK1;
            eoi  = SEL && WR && ADDR == 3'd3 && WDATA[g];
            if (m_phase[g] == P_IDLE) begin
                if (cand != 0) m_phase[g] = P_REQ;
            end else if (m_phase[g] == P_REQ) begin
                if (cand == 0) m_phase[g] = P_IDLE;
                else if (ack) begin
                    first = 0;
                    while (!cand[first]) first++;
                    m_vec[g]   = first;
                    clr[first] = 1'b1;
                    m_phase[g] = P_SVC;
                end
            end else if (eoi) begin
                m_phase[g] = P_IDLE;
            end
        end
        m_pend = (m_pend & ~w1c & ~clr) | new_edges;
        if (SEL && WR && ADDR == 3'd1) m_mask = WDATA[7:0];
`ifdef MCU_INTC_POLARITY_EN
        if (SEL && WR && ADDR == 3'd4) m_pol = WDATA[7:0];
`endif
        if (SEL && RD) m_rdata = rd_val;
        m_samp.push_front(INTS);
        m_samp = m_samp[0:2];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic quiet();
        SEL = 0; RD = 0; WR = 0; INT_ACK0 = 0; INT_ACK1 = 0; RESET = 0;
    endtask

    // One clock: update the model, let the DUT take the edge, then compare on the falling edge.
    task automatic cycle();
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        check_val("int0",  {15'b0, INT0}, {15'b0, m_phase[0] == P_REQ});
        check_val("int1",  {15'b0, INT1}, {15'b0, m_phase[1] == P_REQ});
        check_val("rdata", RDATA, m_rdata);
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
        SEL = 1; WR = 1; ADDR = a; WDATA = d;
        cycle();
        quiet();
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [15:0] d);
        SEL = 1; RD = 1; ADDR = a;
        cycle();
        quiet();
        d = RDATA;
    endtask

    task automatic ack_grp(input int g);
        if (g == 0) INT_ACK0 = 1; else INT_ACK1 = 1;
        cycle();
        quiet();
    endtask

    task automatic pulse(input logic [7:0] bits);
        INTS = INTS | bits;
        cycle();
        INTS = INTS & ~bits;
    endtask

    logic [15:0] rv;

    initial begin
        quiet();
        RESET = 1; INTS = '0; ADDR = '0; WDATA = '0;
        model_reset();
        wait_n(2);
        RESET = 0;
        rd_reg(3'd0, rv); check_val("rst_pend", rv, 16'h0000);
        rd_reg(3'd1, rv); check_val("rst_mask", rv, 16'h0000);

        // Scenario 1: single source through the full request/ack/EOI sequence.
        wr_reg(3'd1, 16'h0001);
        pulse(8'h01);
        wait_n(3);
        check_val("t1_int0", {15'b0, INT0}, 16'h0001);
        rd_reg(3'd0, rv); check_val("t1_pend", rv, 16'h0001);
        ack_grp(0);
        check_val("t1_int0_ack", {15'b0, INT0}, 16'h0000);
        rd_reg(3'd2, rv); check_val("t1_vec", rv & 16'h0087, 16'h0080);
        wr_reg(3'd3, 16'h0001);
        rd_reg(3'd2, rv); check_val("t1_eoi", rv & 16'h0080, 16'h0000);

        // Scenario 2: simultaneous sources, the lower index is served first.
        wr_reg(3'd1, 16'h0006);
        pulse(8'h06);
        wait_n(4);
        ack_grp(0);
        rd_reg(3'd2, rv); check_val("t2_vec_a", rv & 16'h0007, 16'h0001);
        rd_reg(3'd0, rv); check_val("t2_pend", rv, 16'h0004);
        wr_reg(3'd3, 16'h0001);
        wait_n(2);
        check_val("t2_reassert", {15'b0, INT0}, 16'h0001);
        ack_grp(0);
        rd_reg(3'd2, rv); check_val("t2_vec_b", rv & 16'h0007, 16'h0002);
        wr_reg(3'd3, 16'h0001);

        // Scenario 3: the two groups are independent.
        wr_reg(3'd1, 16'h0011);
        pulse(8'h11);
        wait_n(4);
        check_val("t3_both", {14'b0, INT1, INT0}, 16'h0003);
        ack_grp(1);
        check_val("t3_int0_kept", {14'b0, INT1, INT0}, 16'h0001);
        rd_reg(3'd2, rv); check_val("t3_vec1", (rv >> 12) & 16'h0007, 16'h0004);
        ack_grp(0);
        wr_reg(3'd3, 16'h0003);
        wait_n(2);

        // Scenario 4: an edge on a masked source still latches; unmasking raises it.
        wr_reg(3'd1, 16'h0000);
        pulse(8'h20);
        wait_n(4);
        rd_reg(3'd0, rv); check_val("t4_pend", rv, 16'h0020);
        check_val("t4_int1_masked", {15'b0, INT1}, 16'h0000);
        wr_reg(3'd1, 16'h0020);
        cycle();
        check_val("t4_int1_on", {15'b0, INT1}, 16'h0001);
        wr_reg(3'd0, 16'h0020);
        cycle();
        check_val("t4_int1_off", {15'b0, INT1}, 16'h0000);

        // Scenario 5: W1C collides with an arriving edge, then RESET while in service.
        pulse(8'h08);
        cycle();
        wr_reg(3'd0, 16'h0008);
        rd_reg(3'd0, rv); check_val("t5_collision", rv, 16'h0008);
        wr_reg(3'd1, 16'h0008);
        wait_n(2);
        ack_grp(0);
        pulse(8'h01);
        RESET = 1;
        cycle();
        RESET = 0;
        check_val("t5_ints_rst", {14'b0, INT1, INT0}, 16'h0000);
        rd_reg(3'd2, rv); check_val("t5_vec_rst", rv, 16'h0000);
        rd_reg(3'd0, rv); check_val("t5_pend_rst", rv, 16'h0000);
        rd_reg(3'd1, rv); check_val("t5_mask_rst", rv, 16'h0000);

`ifdef MCU_INTC_POLARITY_EN
        // Scenario 6: falling-edge triggering on source 7.
        wr_reg(3'd4, 16'h0080);
        INTS[7] = 1'b1;
        wait_n(4);
        rd_reg(3'd0, rv); check_val("t6_rise_ignored", rv, 16'h0000);
        INTS[7] = 1'b0;
        wait_n(4);
        rd_reg(3'd0, rv); check_val("t6_fall", rv, 16'h0080);
        wr_reg(3'd0, 16'h00FF);
`else
        wr_reg(3'd4, 16'h00FF);
        rd_reg(3'd4, rv); check_val("t6_pol_absent", rv, 16'h0000);
`endif

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            RESET    = ($urandom_range(0, 599) == 0);
            INTS     = INTS ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            SEL      = ($urandom_range(0, 2) != 0);
            RD       = ($urandom_range(0, 2) == 0);
            WR       = ($urandom_range(0, 3) == 0);
            ADDR     = 3'($urandom_range(0, 7));
            WDATA    = 16'($urandom);
            if (ADDR == 3'd1 && $urandom_range(0, 1) == 0) WDATA[7:0] = 8'hFF;
            INT_ACK0 = ($urandom_range(0, 3) == 0);
            INT_ACK1 = ($urandom_range(0, 3) == 0);
            cycle();
        end
        quiet();
        wait_n(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
